// File: rtl/core_dbus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : core_dbus_bridge
//  Description : Bridges the core's load/store data bus onto a single-port
//                synchronous SRAM. Stores are posted into a small write
//                buffer (FIFO) and drained whenever the SRAM port is idle.
//                Loads that hit a buffered store are forwarded in the same
//                cycle (youngest match wins). Loads that miss issue an SRAM
//                read and stall the core for exactly one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W          SRAM word-address width
//    WB_DEPTH        write-buffer entries (power of two, >= 2)
//  Ports
//    clk             sole clock, rising edge
//    rst             synchronous active-high reset
//    core_w_enable_i store request
//    core_w_addr_i   store byte address
//    core_w_data_i   store data (full word)
//    core_r_enable_i load request
//    core_r_addr_i   load byte address
//    core_r_data_o   load data (0 when no load completes)
//    core_r_valid_o  load data valid this cycle
//    hold_req_o      stall request to the pipeline controller
//    wb_empty_o      write buffer empty
//    sram_ce_o       SRAM access strobe
//    sram_we_o       1 = write, 0 = read
//    sram_addr_o     SRAM word address
//    sram_wdata_o    SRAM write data
//    sram_rdata_i    SRAM read data, valid the cycle after a read strobe
// ============================================================================
module core_dbus_bridge #(
   parameter int ADDR_W   = 14,
   parameter int WB_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_w_enable_i,
   input  logic [31:0]       core_w_addr_i,
   input  logic [31:0]       core_w_data_i,
   input  logic              core_r_enable_i,
   input  logic [31:0]       core_r_addr_i,
   output logic [31:0]       core_r_data_o,
   output logic              core_r_valid_o,
   output logic              hold_req_o,
   output logic              wb_empty_o,
   output logic              sram_ce_o,
   output logic              sram_we_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [31:0]       sram_wdata_o,
   input  logic [31:0]       sram_rdata_i
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(WB_DEPTH);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   state_t             state;

   // Write buffer storage and bookkeeping
   logic [ADDR_W-1:0]  wb_addr [WB_DEPTH];
   logic [31:0]        wb_data [WB_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     count;

   // Word addresses: byte-offset bits and bits above the SRAM range are dropped
   logic [ADDR_W-1:0]  ld_addr;
   logic [ADDR_W-1:0]  st_addr;
   logic               unused_addr_bits;

   assign ld_addr = core_r_addr_i[ADDR_W+1:2];
   assign st_addr = core_w_addr_i[ADDR_W+1:2];
   assign unused_addr_bits = ^{core_r_addr_i[31:ADDR_W+2], core_r_addr_i[1:0],
                               core_w_addr_i[31:ADDR_W+2], core_w_addr_i[1:0]};

   // ------------------------------------------------------------------------
   // Store-to-load forwarding. Entries are scanned oldest to youngest from the
   // head so a later match overrides an earlier one: the youngest store wins.
   // ------------------------------------------------------------------------
   logic               hit;
   logic [31:0]        hit_data;
   logic [PTR_W-1:0]   scan_idx;

   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      scan_idx = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
         scan_idx = rd_ptr + PTR_W'(k);
         if (((PTR_W+1)'(k) < count) && (wb_addr[scan_idx] == ld_addr)) begin
            hit      = 1'b1;
            hit_data = wb_data[scan_idx];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Cycle decisions. Everything is qualified with !rst so that nothing is
   // issued to the SRAM (in particular no drain write) during a reset cycle.
   // ------------------------------------------------------------------------
   logic active;
   logic in_idle;
   logic ld_req;
   logic rd_hit;
   logic rd_issue;
   logic rd_done;
   logic drain;
   logic full;
   logic st_req;
   logic enq;
   logic st_block;

   assign active   = ~rst;
   assign in_idle  = (state == IDLE);
   assign ld_req   = active & in_idle & core_r_enable_i;
   assign rd_hit   = ld_req & hit;
   assign rd_issue = ld_req & ~hit;
   assign rd_done  = active & (state == RD_WAIT);
   // A read issue owns the SRAM port; otherwise the head drains if present
   assign drain    = active & ~rd_issue & (count != '0);
   assign full     = (count == FULL_COUNT);
   assign st_req   = active & in_idle & core_w_enable_i;
   // A full buffer still accepts a store when its head drains this cycle
   assign enq      = st_req & (~full | drain);
   assign st_block = st_req & full & ~drain;

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      sram_ce_o    = rd_issue | drain;
      sram_we_o    = drain;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      if (rd_issue) begin
         sram_addr_o = ld_addr;
      end else if (drain) begin
         sram_addr_o  = wb_addr[rd_ptr];
         sram_wdata_o = wb_data[rd_ptr];
      end
   end

   always_comb begin
      core_r_valid_o = rd_hit | rd_done;
      core_r_data_o  = '0;
      if (rd_hit) begin
         core_r_data_o = hit_data;
      end else if (rd_done) begin
         core_r_data_o = sram_rdata_i;
      end
   end

   assign hold_req_o = rd_issue | st_block;
   assign wb_empty_o = (count == '0);

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    state <= rd_issue ? RD_WAIT : IDLE;
            RD_WAIT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Write buffer: push at wr_ptr, pop at rd_ptr, pointers wrap naturally
   // because the depth is a power of two.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < WB_DEPTH; i++) begin
            wb_addr[i] <= '0;
            wb_data[i] <= '0;
         end
      end else begin
         if (enq) begin
            wb_addr[wr_ptr] <= st_addr;
            wb_data[wr_ptr] <= core_w_data_i;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (drain) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({enq, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_dbus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_core_dbus_bridge
//  Description : Testbench for core_dbus_bridge. Directed scenarios followed
//                by randomized core traffic; expected SRAM transactions, load
//                data and per-cycle status are queued by a reference model
//                and compared by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_dbus_bridge;

   localparam int ADDR_W    = 14;
   localparam int WB_DEPTH  = 2;
   localparam int MEM_WORDS = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              core_w_enable_i = 1'b0;
   logic [31:0]       core_w_addr_i = '0;
   logic [31:0]       core_w_data_i = '0;
   logic              core_r_enable_i = 1'b0;
   logic [31:0]       core_r_addr_i = '0;
   logic [31:0]       core_r_data_o;
   logic              core_r_valid_o;
   logic              hold_req_o;
   logic              wb_empty_o;
   logic              sram_ce_o;
   logic              sram_we_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic [31:0]       sram_wdata_o;
   logic [31:0]       sram_rdata_i = '0;

   always #5 clk = ~clk;

   core_dbus_bridge #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .core_w_enable_i (core_w_enable_i),
      .core_w_addr_i   (core_w_addr_i),
      .core_w_data_i   (core_w_data_i),
      .core_r_enable_i (core_r_enable_i),
      .core_r_addr_i   (core_r_addr_i),
      .core_r_data_o   (core_r_data_o),
      .core_r_valid_o  (core_r_valid_o),
      .hold_req_o      (hold_req_o),
      .wb_empty_o      (wb_empty_o),
      .sram_ce_o       (sram_ce_o),
      .sram_we_o       (sram_we_o),
      .sram_addr_o     (sram_addr_o),
      .sram_wdata_o    (sram_wdata_o),
      .sram_rdata_i    (sram_rdata_i)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] init_word(input int i);
      if (i == 32'h80) return 32'h1234_5678;
      return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endfunction

   // ---------------- SRAM environment model ----------------
   logic [31:0] mem [MEM_WORDS];
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (sram_ce_o) begin
            if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata_i     <= mem[sram_addr_o];
         end
      end
   end

   // ---------------- Reference model and scoreboard queues ----------------
   typedef struct packed { logic [ADDR_W-1:0] a; logic [31:0] d; } ent_t;
   typedef struct packed { logic we; logic [ADDR_W-1:0] a; logic [31:0] d; } txn_t;
   typedef struct packed { logic hold; logic empty; logic valid; logic ce; } flg_t;

   logic [31:0] ref_mem [MEM_WORDS];
   ent_t        mq[$];
   txn_t        exp_sram[$];
   logic [31:0] exp_load[$];
   flg_t        exp_flg[$];
   logic        m_wait = 1'b0;
   logic [31:0] m_pend = '0;

   // Predicts this cycle's behaviour from the bridge rules: loads first
   // against the buffer as it stood, then a drain if the port is free, then
   // the store if there is (or will be) room.
   task automatic model_step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                             input logic re, input logic [31:0] ra, input logic r);
      flg_t f;
      int   sz;
      logic was_wait, miss, hit, drained;
      logic [ADDR_W-1:0] la;
      logic [31:0] hd;
      ent_t e;
      if (r) begin
         mq.delete();
         m_wait = 1'b0;
         return;
      end
      f = '0; sz = mq.size(); was_wait = m_wait; miss = 0; hit = 0; drained = 0; hd = '0;
      f.empty = (sz == 0);
      if (was_wait) begin
         exp_load.push_back(m_pend);
         f.valid = 1'b1;
         m_wait = 1'b0;
      end else if (re) begin
         la = ra[ADDR_W+1:2];
         for (int i = sz - 1; i >= 0; i--) begin
            if (!hit && mq[i].a == la) begin hit = 1; hd = mq[i].d; end
         end
         if (hit) begin
            exp_load.push_back(hd);
            f.valid = 1'b1;
         end else begin
            miss = 1;
            exp_sram.push_back({1'b0, la, 32'h0});
            m_pend = ref_mem[la];
            m_wait = 1'b1;
         end
      end
      if (!miss && sz > 0) begin
         e = mq.pop_front();
         exp_sram.push_back({1'b1, e.a, e.d});
         ref_mem[e.a] = e.d;
         drained = 1;
      end
      if (!was_wait && we) begin
         if (sz < WB_DEPTH || drained) mq.push_back({wa[ADDR_W+1:2], wd});
         else f.hold = 1'b1;
      end
      if (miss) f.hold = 1'b1;
      f.ce = miss | drained;
      exp_flg.push_back(f);
   endtask

   task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic re, input logic [31:0] ra, input logic r);
      @(posedge clk);
      #1;
      rst             = r;
      core_w_enable_i = we;
      core_w_addr_i   = wa;
      core_w_data_i   = wd;
      core_r_enable_i = re;
      core_r_addr_i   = ra;
      model_step(we, wa, wd, re, ra, r);
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   // ---------------- Monitor ----------------
   always @(negedge clk) begin
      flg_t f;
      txn_t t;
      logic [31:0] d;
      if (!rst) begin
         if (exp_flg.size() == 0) begin
            checks++; errors++;
            $display("FAIL flags_queue_empty actual=0 expected=1");
         end else begin
            f = exp_flg.pop_front();
            chk("hold_req", hold_req_o, f.hold);
            chk("wb_empty", wb_empty_o, f.empty);
            chk("r_valid", core_r_valid_o, f.valid);
            chk("sram_ce", sram_ce_o, f.ce);
         end
         if (core_r_valid_o) begin
            if (exp_load.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_load data=%0h expected=none", core_r_data_o);
            end else begin
               d = exp_load.pop_front();
               chk("load_data", core_r_data_o, d);
            end
         end else begin
            chk("rdata_idle_zero", core_r_data_o, 0);
         end
         if (sram_ce_o) begin
            if (exp_sram.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_sram we=%0d addr=%0h expected=none", sram_we_o, sram_addr_o);
            end else begin
               t = exp_sram.pop_front();
               chk("sram_txn", {sram_we_o, sram_addr_o, sram_wdata_o}, t);
            end
         end else begin
            chk("sram_idle_zero", {sram_we_o, sram_addr_o, sram_wdata_o}, 0);
         end
      end
   end

   // ---------------- Stimulus ----------------
   initial begin
      logic we, re, r;
      logic [31:0] wa, ra;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

      cycle(0, 0, 0, 0, 0, 1'b1);
      cycle(0, 0, 0, 0, 0, 1'b1);
      idle_cycle();
      @(negedge clk);
      chk("reset_wb_empty", wb_empty_o, 1);
      chk("reset_outputs", {core_r_valid_o, hold_req_o, sram_ce_o, core_r_data_o}, 0);

      // Store then forwarded load
      cycle(1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
      cycle(0, 0, 0, 1, 32'h100, 0);
      @(negedge clk);
      chk("fwd_data", core_r_data_o, 32'hDEAD_BEEF);
      chk("fwd_valid_hold", {core_r_valid_o, hold_req_o}, 2'b10);

      // Load miss: one stall cycle, then SRAM data
      cycle(0, 0, 0, 1, 32'h200, 0);
      @(negedge clk);
      chk("miss_hold", {hold_req_o, core_r_valid_o}, 2'b10);
      idle_cycle();
      @(negedge clk);
      chk("miss_data", core_r_data_o, 32'h1234_5678);
      chk("miss_valid_hold", {core_r_valid_o, hold_req_o}, 2'b10);

      // Two stores, load miss, third store, then read it back
      cycle(1, 32'h700, 32'h1111_0001, 0, 0, 0);
      cycle(1, 32'h704, 32'h1111_0002, 0, 0, 0);
      cycle(0, 0, 0, 1, 32'h800, 0);
      idle_cycle();
      cycle(1, 32'h708, 32'h1111_0003, 0, 0, 0);
      idle_cycle();
      cycle(0, 0, 0, 1, 32'h708, 0);
      idle_cycle();
      @(negedge clk);
      chk("third_store_data", core_r_data_o, 32'h1111_0003);

      // Youngest store to the same word wins
      cycle(1, 32'h10, 32'h1, 0, 0, 0);
      cycle(1, 32'h10, 32'h2, 0, 0, 0);
      cycle(0, 0, 0, 1, 32'h10, 0);
      @(negedge clk);
      chk("youngest_data", core_r_data_o, 32'h2);

      // Buffered stores and an in-flight read discarded by reset
      idle_cycle();
      idle_cycle();
      cycle(1, 32'h500, 32'hAAAA_0001, 0, 0, 0);
      cycle(1, 32'h504, 32'hAAAA_0002, 1, 32'h600, 0);
      cycle(0, 0, 0, 0, 0, 1'b1);
      idle_cycle();
      @(negedge clk);
      chk("post_rst_empty_ce", {wb_empty_o, sram_ce_o}, 2'b10);
      idle_cycle();
      idle_cycle();
      @(negedge clk);
      chk("rst_mem_140", mem[14'h140], init_word(32'h140));
      chk("rst_mem_141", mem[14'h141], init_word(32'h141));

      // Simultaneous load and store to 0x40: load sees old data
      cycle(1, 32'h40, 32'hCAFE_F00D, 1, 32'h40, 0);
      idle_cycle();
      @(negedge clk);
      chk("same_addr_old", core_r_data_o, init_word(32'h10));
      chk("same_addr_drain", {sram_we_o, sram_addr_o}, {1'b1, 14'h10});
      cycle(0, 0, 0, 1, 32'h40, 0);
      idle_cycle();
      @(negedge clk);
      chk("same_addr_new", core_r_data_o, 32'hCAFE_F00D);

      // Randomized traffic over a small word window with junk in ignored bits
      for (int n = 0; n < 3000; n++) begin
         we = $urandom_range(0, 1);
         re = ($urandom_range(0, 99) < 60);
         r  = ($urandom_range(0, 199) == 0);
         wa = ($urandom & 32'hFFFF_0003) | ((32'h20 + $urandom_range(0, 7)) << 2);
         ra = ($urandom & 32'hFFFF_0003) | ((32'h20 + $urandom_range(0, 7)) << 2);
         cycle(we, wa, $urandom, re, ra, r);
      end
      idle_cycle();
      idle_cycle();
      idle_cycle();

      cycle(0, 0, 0, 0, 0, 1'b1);
      @(negedge clk);
      chk("flags_left", exp_flg.size(), 0);
      chk("sram_left", exp_sram.size(), 0);
      chk("load_left", exp_load.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/core_dbus_bridge.md
CORE_DBUS_BRIDGE -- requirements
Module: core_dbus_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: SRAM word-address width.
REQ-002 SHALL have parameter WB_DEPTH, default 2: write-buffer entries; power of two, >=2.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port core_w_enable_i, input, 1: core store request.
REQ-006 SHALL have port core_w_addr_i, input, 32: store byte address.
REQ-007 SHALL have port core_w_data_i, input, 32: store data, full word.
REQ-008 SHALL have port core_r_enable_i, input, 1: core load request.
REQ-009 SHALL have port core_r_addr_i, input, 32: load byte address.
REQ-010 SHALL have port core_r_data_o, output, 32: load data.
REQ-011 SHALL have port core_r_valid_o, output, 1: core_r_data_o valid this cycle.
REQ-012 SHALL have port hold_req_o, output, 1: stall request to pipeline ctrl.
REQ-013 SHALL have port wb_empty_o, output, 1: write buffer empty.
REQ-014 SHALL have port sram_ce_o, output, 1: SRAM access strobe.
REQ-015 SHALL have port sram_we_o, output, 1: 1 write, 0 read.
REQ-016 SHALL have port sram_addr_o, output, ADDR_W: SRAM word address.
REQ-017 SHALL have port sram_wdata_o, output, 32: SRAM write data.
REQ-018 SHALL have port sram_rdata_i, input, 32: read data, valid the cycle after a read strobe.

Function
REQ-019 SHALL derive word address as addr[ADDR_W+1:2]; bits [1:0] and above ADDR_W+1 ignored.
REQ-020 SHALL hold writes in a FIFO of WB_DEPTH {word addr, data} entries, wrapping read/write pointers modulo WB_DEPTH.
REQ-021 SHALL enqueue a write when core_w_enable_i=1 in IDLE and FIFO not full, or full with a drain this same cycle.
REQ-022 SHALL assert hold_req_o and not enqueue when a write arrives with FIFO full and no drain this cycle; core re-presents.
REQ-023 SHALL implement FSM states IDLE and RD_WAIT.
REQ-024 SHALL, in IDLE on a load whose word address matches any valid FIFO entry, return the youngest match combinationally, core_r_valid_o=1, hold_req_o=0, remain IDLE.
REQ-025 SHALL, in IDLE on a load miss, issue sram_ce_o=1, sram_we_o=0, sram_addr_o=load word address, assert hold_req_o, go to RD_WAIT.
REQ-026 SHALL, in RD_WAIT, drive core_r_data_o=sram_rdata_i, core_r_valid_o=1, hold_req_o=0, ignore core inputs, return to IDLE (miss = one stall cycle).
REQ-027 SHALL drain the FIFO head (sram_ce_o=1, sram_we_o=1, head addr/data, pop) in any cycle the port is not used by a read issue and FIFO non-empty; one drain per cycle max.
REQ-028 SHALL give a read issue priority over drain in the same cycle.
REQ-029 SHALL, with core_w_enable_i and core_r_enable_i both 1 in IDLE, serve the load first against pre-cycle FIFO contents, then enqueue the store per REQ-021/022.
REQ-030 SHALL handle an enqueue and pop in one cycle with FIFO occupancy unchanged.
REQ-031 SHALL drive core_r_data_o=0 and core_r_valid_o=0 when no load completes; sram_* outputs 0 when sram_ce_o=0.
REQ-032 SHALL drive wb_empty_o=1 iff occupancy is 0, for ctrl to fence before fence/reset-sensitive operations.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, go to IDLE, zero FIFO pointers and occupancy, zero all registered state.
REQ-034 SHALL discard buffered writes and any in-flight read on reset mid-operation, with no SRAM write issued in the reset cycle.
REQ-035 SHALL drive all outputs 0, except wb_empty_o=1, from the first cycle after reset.

Verification
REQ-036 SHALL cover: store 0x100<-0xDEADBEEF, then load 0x100 next cycle -> forwarded 0xDEADBEEF, valid same cycle, hold_req_o=0.
REQ-037 SHALL cover: load 0x200 miss, SRAM word 0x80=0x12345678 -> hold_req_o=1 one cycle, then core_r_data_o=0x12345678 valid.
REQ-038 SHALL cover: WB_DEPTH=2, two stores then load miss then store -> third store held until RD_WAIT drain frees a slot.
REQ-039 SHALL cover: stores 0x10<-1 then 0x10<-2 undrained, load 0x10 -> returns 2 (youngest wins).
REQ-040 SHALL cover: two stores buffered, rst pulse -> no SRAM write after reset, wb_empty_o=1, SRAM contents unchanged.
REQ-041 SHALL cover: load and store asserted together, same address 0x40 -> load returns old SRAM data, store then drained.
